// File: rtl/ex_mem_reg_pkg.sv
// Shared defaults and control-word layout for the EX/MEM register slice.
package ex_mem_reg_pkg;

  localparam int unsigned EXM_ADDR_W = 10;
  localparam int unsigned EXM_DATA_W = 32;
  localparam int unsigned EXM_REG_W  = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic misalign;
    logic w_src;
    logic range_err;
  } ctrl_t;

  // Control word of an empty MEM slot, loaded on reset and flush.
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/ex_mem_reg_store_fwd_detect.sv
// Store-after-writeback hazard comparator: flags a store whose rt is written
// by the instruction one stage ahead of it. $0 never forwards.
module store_fwd_detect
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned REG_W = EXM_REG_W
) (
  input  logic             st_write,
  input  logic             st_valid,
  input  logic             prev_reg_write,
  input  logic             prev_valid,
  input  logic [REG_W-1:0] prev_rd,
  input  logic [REG_W-1:0] st_rt,
  output logic             fwd
);

  always_comb begin
    fwd = st_write & st_valid & prev_reg_write & prev_valid &
          (prev_rd == st_rt) & (st_rt != REG_W'(REG_ZERO));
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register feeding the data memory, with store gating and
// store-data forwarding select. Optional macro: EX_MEM_RANGE_CHECK_EN.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = EXM_ADDR_W,
  parameter int unsigned DATA_W = EXM_DATA_W,
  parameter int unsigned REG_W  = EXM_REG_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_write,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_dmwr,
  output logic              mem_w_src,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
`ifdef EX_MEM_RANGE_CHECK_EN
  output logic              mem_range_err,
`endif
  output logic              mem_misalign
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              w_src_next;
  logic              ex_ls;

  store_fwd_detect #(.REG_W(REG_W)) u_fwd (
    .st_write       (ex_mem_write),
    .st_valid       (ex_valid),
    .prev_reg_write (ctrl_q.reg_write),
    .prev_valid     (ctrl_q.valid),
    .prev_rd        (rd_q),
    .st_rt          (ex_rt),
    .fwd            (w_src_next)
  );

  always_comb begin
    ex_ls  = ex_valid & (ex_mem_write | ex_mem_read);
    ctrl_d = ctrl_q;
    alu_d  = alu_q;
    din_d  = din_q;
    rd_d   = rd_q;
    if (!stall) begin
      alu_d = ex_alu_result;
      din_d = ex_rt_data;
      rd_d  = ex_rd;
      if (flush) begin
        ctrl_d = BUBBLE;
      end else begin
        ctrl_d.valid     = ex_valid;
        ctrl_d.reg_write = ex_reg_write & ex_valid;
        ctrl_d.mem_read  = ex_mem_read & ex_valid;
        ctrl_d.mem_write = ex_mem_write & ex_valid;
        ctrl_d.misalign  = ex_ls & (ex_alu_result[1:0] != 2'b00);
        ctrl_d.w_src     = w_src_next;
`ifdef EX_MEM_RANGE_CHECK_EN
        ctrl_d.range_err = ex_ls & (ex_alu_result[DATA_W-1:ADDR_W+2] != '0);
`else
        ctrl_d.range_err = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl_q <= BUBBLE;
      alu_q  <= '0;
      din_q  <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      din_q  <= din_d;
      rd_q   <= rd_d;
    end
  end

  // Write enable looks at the live stall so a held store fires only once.
  always_comb begin
    mem_dmwr = ctrl_q.mem_write & ctrl_q.valid & ~ctrl_q.misalign &
               ~ctrl_q.range_err & ~stall;
  end

  assign mem_valid      = ctrl_q.valid;
  assign mem_addr       = alu_q[ADDR_W+1:2];
  assign mem_din        = din_q;
  assign mem_w_src      = ctrl_q.w_src;
  assign mem_alu_result = alu_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = ctrl_q.reg_write;
  assign mem_mem_read   = ctrl_q.mem_read;
  assign mem_misalign   = ctrl_q.misalign;
`ifdef EX_MEM_RANGE_CHECK_EN
  assign mem_range_err  = ctrl_q.range_err;
`endif

endmodule
